// File: rtl/bsg_timeslice_arbiter_pkg.sv
// Shared types for the time-slice arbiter: the two-state grant FSM encoding.
package bsg_timeslice_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/bsg_rr_select.sv
// Rotate-priority pick: returns the first set request at or above ptr,
// wrapping modulo els_p. Purely combinational.
module bsg_rr_select #(
  parameter int els_p = 4
) (
  input  logic [els_p-1:0]         reqs,
  input  logic [$clog2(els_p)-1:0] ptr,
  output logic                     valid,
  output logic [$clog2(els_p)-1:0] index
);

  localparam int id_w = $clog2(els_p);

  // Walk offsets from farthest to nearest so the nearest set bit to ptr wins
  always_comb begin
    int j;
    valid = 1'b0;
    index = '0;
    j     = 0;
    for (int k = els_p - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= els_p) j = j - els_p;
      if (reqs[id_w'(j)]) begin
        valid = 1'b1;
        index = id_w'(j);
      end
    end
  end

endmodule

// File: rtl/bsg_timeslice_arbiter.sv
// Round-robin time-slice arbiter: a requester holds the grant for up to
// quantum+1 cycles (or until it drops its request), then the grant rotates.
module bsg_timeslice_arbiter
  import bsg_timeslice_arbiter_pkg::*;
#(
  parameter int els_p   = 4,
  parameter int width_p = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [els_p-1:0]         reqs_i,
  input  logic [width_p-1:0]       quantum_i,
  output logic [els_p-1:0]         grants_o,
  output logic                     grant_v_o,
  output logic [$clog2(els_p)-1:0] grant_id_o,
  output logic [width_p-1:0]       slice_cnt_o,
  output logic                     slice_done_o
);

  localparam int id_w = $clog2(els_p);

  state_e             state_r, state_n;
  logic [id_w-1:0]    grant_id_r, grant_id_n;
  logic [id_w-1:0]    rr_ptr_r, rr_ptr_n;
  logic [width_p-1:0] slice_cnt_r, slice_cnt_n;
  logic [width_p-1:0] limit_r, limit_n;

  logic [id_w-1:0]    next_ptr;
  logic [id_w-1:0]    sel_ptr;
  logic               sel_v;
  logic [id_w-1:0]    sel_idx;
  logic               slice_done;

  // Pointer the slice would hand over to, and the pointer used for this pick
  always_comb begin
    next_ptr = (grant_id_r == id_w'(els_p - 1)) ? '0 : grant_id_r + id_w'(1);
    sel_ptr  = (state_r == GRANT) ? next_ptr : rr_ptr_r;
  end

  bsg_rr_select #(.els_p(els_p)) select (
    .reqs  (reqs_i),
    .ptr   (sel_ptr),
    .valid (sel_v),
    .index (sel_idx)
  );

  // Slice ends at the sampled limit or when the holder releases its request
  always_comb begin
    slice_done = (state_r == GRANT) &&
                 ((slice_cnt_r == limit_r) || !reqs_i[grant_id_r]);
  end

  // Next-state logic: start, extend, hand over or close a slice
  always_comb begin
    state_n     = state_r;
    grant_id_n  = grant_id_r;
    rr_ptr_n    = rr_ptr_r;
    slice_cnt_n = slice_cnt_r;
    limit_n     = limit_r;
    case (state_r)
      IDLE: begin
        if (sel_v) begin
          state_n     = GRANT;
          grant_id_n  = sel_idx;
          slice_cnt_n = '0;
          limit_n     = quantum_i;
        end
      end
      GRANT: begin
        if (slice_done) begin
          rr_ptr_n    = next_ptr;
          slice_cnt_n = '0;
          if (sel_v) begin
            grant_id_n = sel_idx;
            limit_n    = quantum_i;
          end else begin
            state_n    = IDLE;
            grant_id_n = '0;
          end
        end else begin
          slice_cnt_n = slice_cnt_r + width_p'(1);
        end
      end
      default: begin
        state_n     = IDLE;
        grant_id_n  = '0;
        slice_cnt_n = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= IDLE;
      grant_id_r  <= '0;
      rr_ptr_r    <= '0;
      slice_cnt_r <= '0;
      limit_r     <= '0;
    end else begin
      state_r     <= state_n;
      grant_id_r  <= grant_id_n;
      rr_ptr_r    <= rr_ptr_n;
      slice_cnt_r <= slice_cnt_n;
      limit_r     <= limit_n;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    grants_o     = (state_r == GRANT) ? ({{(els_p-1){1'b0}}, 1'b1} << grant_id_r) : '0;
    grant_v_o    = (state_r == GRANT);
    grant_id_o   = grant_id_r;
    slice_cnt_o  = slice_cnt_r;
    slice_done_o = slice_done;
  end

endmodule

// File: tb/tb_bsg_timeslice_arbiter.sv
// Directed bench for the time-slice arbiter with hand-computed expectations.
module tb_bsg_timeslice_arbiter;

  logic       clk_i;
  logic       reset_n_i;
  logic [3:0] reqs_i;
  logic [7:0] quantum_i;
  logic [3:0] grants_o;
  logic       grant_v_o;
  logic [1:0] grant_id_o;
  logic [7:0] slice_cnt_o;
  logic       slice_done_o;

  int testsRun = 0;
  int testsFailed = 0;

  bsg_timeslice_arbiter #(.els_p(4), .width_p(8)) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .reqs_i       (reqs_i),
    .quantum_i    (quantum_i),
    .grants_o     (grants_o),
    .grant_v_o    (grant_v_o),
    .grant_id_o   (grant_id_o),
    .slice_cnt_o  (slice_cnt_o),
    .slice_done_o (slice_done_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] reqs, input logic [7:0] quantum);
    reqs_i    = reqs;
    quantum_i = quantum;
    #1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic expectIdle(input string tag);
    checkOutput({tag, ".v"},    32'(grant_v_o),    32'd0);
    checkOutput({tag, ".g"},    32'(grants_o),     32'd0);
    checkOutput({tag, ".id"},   32'(grant_id_o),   32'd0);
    checkOutput({tag, ".cnt"},  32'(slice_cnt_o),  32'd0);
    checkOutput({tag, ".done"}, 32'(slice_done_o), 32'd0);
  endtask

  task automatic expectSlice(input string tag, input int id, input int cnt, input bit done);
    logic [3:0] oneHot;
    oneHot = 4'b0001 << id;
    checkOutput({tag, ".v"},    32'(grant_v_o),    32'd1);
    checkOutput({tag, ".g"},    32'(grants_o),     32'(oneHot));
    checkOutput({tag, ".id"},   32'(grant_id_o),   32'(id));
    checkOutput({tag, ".cnt"},  32'(slice_cnt_o),  32'(cnt));
    checkOutput({tag, ".done"}, 32'(slice_done_o), 32'(done));
  endtask

  initial begin
    int rrOrder [6];
    int qzOrder [5];
    rrOrder = '{0, 1, 3, 0, 1, 3};
    qzOrder = '{0, 1, 2, 3, 0};

    reset_n_i = 1'b0;
    applyStimulus(4'b0000, 8'd0);
    step();
    expectIdle("reset");
    @(negedge clk_i);
    reset_n_i = 1'b1;
    step();
    expectIdle("postReset");

    // Single requester, quantum 3, back-to-back re-grant
    applyStimulus(4'b0001, 8'd3);
    checkOutput("single.notYet", 32'(grant_v_o), 32'd0);
    step(); expectSlice("single.c0", 0, 0, 0);
    step(); expectSlice("single.c1", 0, 1, 0);
    step(); expectSlice("single.c2", 0, 2, 0);
    step(); expectSlice("single.c3", 0, 3, 1);
    step(); expectSlice("single.regrant", 0, 0, 0);
    applyStimulus(4'b0000, 8'd3);
    checkOutput("single.release", 32'(slice_done_o), 32'd1);
    step(); expectIdle("single.idle");

    // Early release; pointer is now 1
    applyStimulus(4'b0110, 8'd10);
    step(); expectSlice("early.c0", 1, 0, 0);
    step(); expectSlice("early.c1", 1, 1, 0);
    step();
    applyStimulus(4'b0100, 8'd10);
    expectSlice("early.c2", 1, 2, 1);
    step(); expectSlice("early.next", 2, 0, 0);
    applyStimulus(4'b0000, 8'd10);
    step(); expectIdle("early.idle");

    // Quantum sampled at grant start; pointer is now 3 so requester 0 wraps in
    applyStimulus(4'b0001, 8'd5);
    step(); expectSlice("quant.c0", 0, 0, 0);
    step();
    applyStimulus(4'b0001, 8'd1);
    expectSlice("quant.c1", 0, 1, 0);
    step(); step(); step();
    expectSlice("quant.c4", 0, 4, 0);
    step(); expectSlice("quant.c5", 0, 5, 1);
    step(); expectSlice("quant.n0", 0, 0, 0);
    step(); expectSlice("quant.n1", 0, 1, 1);
    step();
    applyStimulus(4'b0000, 8'd1);
    step(); expectIdle("quant.idle");

    // Async reset mid-slice; pointer is now 1 so requester 2 is picked
    applyStimulus(4'b0100, 8'd7);
    step(); step(); step(); step();
    expectSlice("areset.c3", 2, 3, 0);
    #2;
    reset_n_i = 1'b0;
    #1;
    expectIdle("areset.now");
    applyStimulus(4'b1011, 8'd1);
    step();
    expectIdle("areset.held");
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // Round robin from a cleared pointer, 2-cycle slices, no bubbles
    step();
    for (int s = 0; s < 6; s++) begin
      expectSlice($sformatf("rr%0d.c0", s), rrOrder[s], 0, 0);
      step();
      expectSlice($sformatf("rr%0d.c1", s), rrOrder[s], 1, 1);
      if (s == 5) applyStimulus(4'b0000, 8'd1);
      else step();
    end
    checkOutput("rr.lastDone", 32'(slice_done_o), 32'd1);
    step(); expectIdle("rr.idle0");
    step(); expectIdle("rr.idle1");

    // Quantum 0: one-cycle slices; pointer stayed 0 while idle
    applyStimulus(4'b1111, 8'd0);
    for (int s = 0; s < 5; s++) begin
      step();
      expectSlice($sformatf("q0_%0d", s), qzOrder[s], 0, 1);
    end
    applyStimulus(4'b0000, 8'd0);
    step(); expectIdle("q0.idle");

    // All-ones quantum: 256-cycle slice without counter wrap; pointer is 1
    applyStimulus(4'b0010, 8'hFF);
    step(); expectSlice("max.c0", 1, 0, 0);
    for (int c = 1; c < 255; c++) step();
    expectSlice("max.c254", 1, 254, 0);
    step(); expectSlice("max.c255", 1, 255, 1);
    step(); expectSlice("max.regrant", 1, 0, 0);
    applyStimulus(4'b0000, 8'hFF);
    step(); expectIdle("max.idle");

    // Non-granted requesters toggling do not disturb the slice; pointer is 2
    applyStimulus(4'b0001, 8'd2);
    step(); expectSlice("other.c0", 0, 0, 0);
    applyStimulus(4'b0111, 8'd2);
    checkOutput("other.raise", 32'(slice_done_o), 32'd0);
    step();
    applyStimulus(4'b0001, 8'd2);
    expectSlice("other.c1", 0, 1, 0);
    step();
    applyStimulus(4'b0011, 8'd2);
    expectSlice("other.c2", 0, 2, 1);
    step(); expectSlice("other.next", 1, 0, 0);
    applyStimulus(4'b0000, 8'd2);
    step(); expectIdle("other.idle");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/bsg_timeslice_arbiter.md
BSG_TIMESLICE_ARBITER -- requirements
Module: bsg_timeslice_arbiter

Interface
REQ-001 Parameter els_p, default 4, number of requesters (2..16) SHALL be supported.
REQ-002 Parameter width_p, default 32, width of the quantum and slice counter, SHALL be supported.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n_i  input  1  reset; asynchronous assert, active-low.
REQ-005 reqs_i  input  els_p  per-requester request level, bit i = requester i.
REQ-006 quantum_i  input  width_p  slice limit, inclusive, sampled when a grant starts.
REQ-007 grants_o  output  els_p  one-hot registered grant; all-zero when idle.
REQ-008 grant_v_o  output  1  OR of grants_o.
REQ-009 grant_id_o  output  $clog2(els_p)  index of granted requester; 0 when idle.
REQ-010 slice_cnt_o  output  width_p  cycles elapsed in the current slice, starting at 0.
REQ-011 slice_done_o  output  1  combinational pulse in the last cycle of a slice.

Function
REQ-012 FSM states SHALL be IDLE and GRANT.
REQ-013 IDLE: grants_o=0, slice_cnt_o=0, slice_done_o=0.
REQ-014 IDLE with reqs_i!=0: SHALL select the first set bit at or above rr_ptr, wrapping modulo els_p, and enter GRANT next cycle with grant_id_o=selection, slice_cnt_o=0, limit_r=quantum_i.
REQ-015 GRANT: slice_cnt_o SHALL increment by 1 each cycle.
REQ-016 GRANT: slice_done_o SHALL be 1 when slice_cnt_o==limit_r, or reqs_i[grant_id_o]==0 (early release).
REQ-017 Slice length with no early release SHALL be limit_r+1 cycles; quantum 0 gives a 1-cycle slice.
REQ-018 Quantum of all-ones SHALL give 2^width_p cycles; the counter SHALL never wrap within a slice.
REQ-019 On slice_done_o, rr_ptr SHALL become grant_id_o+1 modulo els_p.
REQ-020 On slice_done_o with any reqs_i bit set, the next grant SHALL start the following cycle with no idle bubble.
- Selection uses the updated rr_ptr and the current reqs_i.
- slice_cnt_o clears to 0; limit_r reloads from quantum_i.
- The same requester is re-granted if it is the only requester.
REQ-021 On slice_done_o with reqs_i==0, the FSM SHALL return to IDLE.
REQ-022 quantum_i changes during a slice SHALL NOT affect that slice.
REQ-023 Requests raised or dropped by non-granted requesters SHALL NOT affect the current slice.
REQ-024 grants_o SHALL never have more than one bit set.

Reset
REQ-025 reset_n_i low SHALL immediately force state IDLE, grants_o=0, grant_id_o=0, slice_cnt_o=0, rr_ptr=0, limit_r=0, independent of clk_i.
REQ-026 Reset asserted mid-slice SHALL abort the slice with no slice_done_o pulse.
REQ-027 After deassertion, the first grant SHALL follow REQ-014 with rr_ptr=0.

Structure
REQ-028 A shared package bsg_timeslice_arbiter_pkg SHALL hold the FSM state enum; no other shared constants.
REQ-029 A single sub-module bsg_rr_select SHALL perform the combinational rotate-priority pick (inputs reqs and ptr; outputs valid and index).
REQ-030 The slice counter and compare SHALL be inline, not a separate module.

Verification
REQ-031 Single requester: reqs_i=4'b0001, quantum_i=3. Required: grant to 0 starts 1 cycle later; slice_cnt_o=0,1,2,3; slice_done_o at cnt 3; immediate re-grant to 0 with cnt=0.
REQ-032 Round robin: reqs_i=4'b1011, quantum_i=1. Required: grant order 0,1,3,0,1,3; each slice 2 cycles; no idle cycles.
REQ-033 Early release: reqs_i=4'b0110, quantum_i=10; drop reqs_i[1] at slice_cnt_o=2. Required: slice_done_o at cnt 2; next cycle grant_id_o=2 with cnt=0.
REQ-034 Quantum sampling: quantum_i=5 at grant start, changed to 1 at cnt 1. Required: done at cnt 5; next slice uses limit 1.
REQ-035 Async reset: drive reset_n_i low between clock edges at cnt 3. Required: grants_o=0 and slice_cnt_o=0 before the next edge; no slice_done_o; first post-reset grant goes to the lowest set requester.
REQ-036 Idle return: reqs_i drops to 0 in the last slice cycle. Required: IDLE next cycle, grants_o=0; no rr_ptr change while idle.
